// File: rtl/priority_encoder_4to2.sv
// Registered priority encoder: the index of the winning unmasked request bit, plus a valid flag.
// Optional registered one-hot output when PRIO_ENC_ONEHOT_EN is defined.
module priority_encoder_4to2 #(
    parameter int WIDTH        = 4,
    parameter int OUT_W        = $clog2(WIDTH),
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] mask,
`ifdef PRIO_ENC_ONEHOT_EN
    output logic [WIDTH-1:0] onehot,
`endif
    output logic [OUT_W-1:0] y,
    output logic             valid
);

    logic [WIDTH-1:0] req;
    logic [OUT_W-1:0] enc_idx;
    logic             enc_any;

    logic [OUT_W-1:0] y_d;
    logic [OUT_W-1:0] y_q;
    logic             valid_d;
    logic             valid_q;

    // The scan direction makes the winning bit the last one written, so no early exit is needed.
    always_comb begin
        req     = a & ~mask;
        enc_any = |req;
        enc_idx = '0;
        if (MSB_PRIORITY) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) enc_idx = OUT_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) enc_idx = OUT_W'(i);
            end
        end
    end

    always_comb begin
        y_d     = y_q;
        valid_d = valid_q;
        if (en) begin
            y_d     = enc_idx;
            valid_d = enc_any;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;

`ifdef PRIO_ENC_ONEHOT_EN
    logic [WIDTH-1:0] onehot_enc;
    logic [WIDTH-1:0] onehot_d;
    logic [WIDTH-1:0] onehot_q;

    // Decoding from enc_idx keeps onehot consistent with y by construction.
    always_comb begin
        onehot_enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            onehot_enc[i] = enc_any && (enc_idx == OUT_W'(i));
        end
        onehot_d = onehot_q;
        if (en) onehot_d = onehot_enc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onehot_q <= '0;
        end else begin
            onehot_q <= onehot_d;
        end
    end

    assign onehot = onehot_q;
`endif

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Self-checking bench for priority_encoder_4to2: MSB- and LSB-priority instances side by side,
// expected results queued when stimulus is driven and popped when the registered output is due.
module tb_priority_encoder_4to2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] a;
    logic [3:0] mask;
    logic [1:0] y_msb;
    logic [1:0] y_lsb;
    logic       valid_msb;
    logic       valid_lsb;
`ifdef PRIO_ENC_ONEHOT_EN
    logic [3:0] onehot_msb;
    logic [3:0] onehot_lsb;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string      tag;
        logic [1:0] y_msb;
        logic [1:0] y_lsb;
        logic       valid;
    } exp_t;

    exp_t sb[$];
    exp_t model;

    priority_encoder_4to2 #(.WIDTH(4), .MSB_PRIORITY(1'b1)) dut_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .mask  (mask),
`ifdef PRIO_ENC_ONEHOT_EN
        .onehot(onehot_msb),
`endif
        .y     (y_msb),
        .valid (valid_msb)
    );

    priority_encoder_4to2 #(.WIDTH(4), .MSB_PRIORITY(1'b0)) dut_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .mask  (mask),
`ifdef PRIO_ENC_ONEHOT_EN
        .onehot(onehot_lsb),
`endif
        .y     (y_lsb),
        .valid (valid_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: search downward from the top for the first set bit.
    function automatic logic [1:0] refMsb(input logic [3:0] r);
        for (int i = 3; i >= 0; i--) if (r[i]) return 2'(i);
        return 2'd0;
    endfunction

    // Reference: search upward from bit 0 for the first set bit.
    function automatic logic [1:0] refLsb(input logic [3:0] r);
        for (int i = 0; i < 4; i++) if (r[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL scoreboard_empty: observed=0 entries expected>=1");
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, "/y_msb"}, {2'b00, y_msb}, {2'b00, e.y_msb});
        cmp({e.tag, "/valid_msb"}, {3'b000, valid_msb}, {3'b000, e.valid});
        cmp({e.tag, "/y_lsb"}, {2'b00, y_lsb}, {2'b00, e.y_lsb});
        cmp({e.tag, "/valid_lsb"}, {3'b000, valid_lsb}, {3'b000, e.valid});
`ifdef PRIO_ENC_ONEHOT_EN
        cmp({e.tag, "/onehot_msb"}, onehot_msb, e.valid ? (4'b0001 << e.y_msb) : 4'b0000);
        cmp({e.tag, "/onehot_lsb"}, onehot_lsb, e.valid ? (4'b0001 << e.y_lsb) : 4'b0000);
`endif
    endtask

    // Registered outputs are forced to zero; queue that as the expectation for an immediate check.
    task automatic pushReset(input string tag);
        model.tag   = tag;
        model.y_msb = 2'd0;
        model.y_lsb = 2'd0;
        model.valid = 1'b0;
        sb.push_back(model);
    endtask

    // Drive one cycle at the falling edge, queue the expected register state, check after the rising edge.
    task automatic applyStimulus(input logic [3:0] a_v, input logic [3:0] m_v, input logic en_v,
                                 input string tag);
        logic [3:0] r;
        @(negedge clk);
        a    = a_v;
        mask = m_v;
        en   = en_v;
        r    = a_v & ~m_v;
        if (en_v) begin
            model.y_msb = refMsb(r);
            model.y_lsb = refLsb(r);
            model.valid = (r != 4'b0000);
        end
        model.tag = tag;
        sb.push_back(model);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        a     = 4'b0000;
        mask  = 4'b0000;
        model = '{tag: "init", y_msb: 2'd0, y_lsb: 2'd0, valid: 1'b0};

        // Asynchronous reset with all requests active: outputs clear before any edge.
        #3;
        rst_n = 1'b0;
        a     = 4'b1111;
        en    = 1'b1;
        #1;
        pushReset("reset_immediate");
        checkOutput();
        repeat (2) begin
            @(posedge clk);
            #1;
            pushReset("reset_hold");
            checkOutput();
        end
        rst_n = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 1'b1, "post_reset");

        applyStimulus(4'b1010, 4'b0000, 1'b1, "a1010");
        applyStimulus(4'b0001, 4'b0000, 1'b1, "a0001");
        applyStimulus(4'b0000, 4'b0000, 1'b1, "a0000");
        applyStimulus(4'b0110, 4'b0000, 1'b1, "a0110");
        applyStimulus(4'b1000, 4'b0000, 1'b1, "a1000");

        applyStimulus(4'b1100, 4'b1000, 1'b1, "mask_top");
        applyStimulus(4'b1100, 4'b1100, 1'b1, "mask_all");

        applyStimulus(4'b0100, 4'b0000, 1'b1, "hold_capture");
        for (int k = 0; k < 3; k++) applyStimulus(4'b1000, 4'b0000, 1'b0, "hold");
        applyStimulus(4'b1000, 4'b0000, 1'b1, "hold_release");

        for (int k = 0; k < 24; k++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                          1'b1, "random");
        end

        // Reset mid-operation: the pending capture is discarded and nothing restores on release.
        applyStimulus(4'b1000, 4'b0000, 1'b1, "pre_midreset");
        @(negedge clk);
        a  = 4'b0100;
        en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        pushReset("midreset_immediate");
        checkOutput();
        @(posedge clk);
        #1;
        pushReset("midreset_hold");
        checkOutput();
        rst_n = 1'b1;
        applyStimulus(4'b0100, 4'b0000, 1'b0, "no_restore");
        applyStimulus(4'b0100, 4'b0000, 1'b1, "after_midreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
